comb_filter_mc: RTL and testbench

Multichannel, parametrised feedback comb filter, the successor to the single-channel fixed-delay comb in the reverb chain. One time-multiplexed delay memory serves all channels. Delay length and feedback gain are set at run time. Input and output use a valid/ready frame handshake, and a post-reset clear sweep guarantees the memory never holds X. It sits between the sample deserialiser and the reverb mixer, and several instances with different delay_len values form the parallel comb bank.

---
 rtl/comb_filter_mc.sv | 190 +++++++++++++++++++
 tb/tb_comb_filter_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/comb_filter_mc.sv
// Multichannel feedback comb filter sharing one time-multiplexed delay memory.
// Optional one-pole damping in the feedback path is enabled by defining COMB_DAMP_EN.
module comb_filter_mc #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2048,
  parameter int CHANNELS   = 2,
  parameter int GAIN_W     = 8,
  parameter int DAMP_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [$clog2(DEPTH)-1:0]   delay_len,
  input  logic [GAIN_W-1:0]          feedback,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  output logic [CHANNELS*DATA_W-1:0] out_data
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MAW    = CW + AW;
  localparam int NWORDS = CHANNELS * DEPTH;
  localparam int PW     = DATA_W + GAIN_W + 1;

  localparam logic signed [PW-1:0] SMAX = {{(GAIN_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(GAIN_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [MAW-1:0]             clr_q;
  logic [CW-1:0]              ch_q;
  logic [AW-1:0]              wp_q;
  logic [AW-1:0]              len_q;
  logic [GAIN_W-1:0]          fb_q;
  logic                       en_q;
  logic [CHANNELS*DATA_W-1:0] in_q;
  logic [CHANNELS*DATA_W-1:0] out_q;
  logic [DATA_W-1:0]          rd_q;

  logic [DATA_W-1:0]          mem [NWORDS];

  logic [MAW-1:0]             addr;
  logic                       mem_we;
  logic [MAW-1:0]             mem_waddr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [DATA_W-1:0]          in_ch;
  logic [DATA_W-1:0]          fb_src;
  logic signed [PW-1:0]       src_x, gain_x, prod, prod_sh, in_x, sum;
  logic [DATA_W-1:0]          wr_data;
  logic [AW-1:0]              len_m1;
  logic                       last_ch;

`ifdef COMB_DAMP_EN
  logic [DATA_W-1:0]          lp_q [CHANNELS];
  logic [DATA_W-1:0]          lp_cur;
  logic signed [DATA_W:0]     lp_diff, lp_step, lp_sum;
  logic [DATA_W-1:0]          lp_new;

  always_comb begin
    lp_cur  = lp_q[ch_q];
    lp_diff = $signed({rd_q[DATA_W-1], rd_q}) - $signed({lp_cur[DATA_W-1], lp_cur});
    lp_step = lp_diff >>> DAMP_SHIFT;
    lp_sum  = $signed({lp_cur[DATA_W-1], lp_cur}) + lp_step;
    // lp_sum lies between lp and delayed, so it always fits back into DATA_W bits
    lp_new  = lp_sum[DATA_W-1:0];
    fb_src  = lp_new;
  end
`else
  always_comb fb_src = rd_q;
`endif

  // Channel c occupies the contiguous block c*DEPTH .. c*DEPTH+DEPTH-1
  assign addr    = {ch_q, wp_q};
  assign in_ch   = in_q[ch_q*DATA_W +: DATA_W];
  assign last_ch = (ch_q == CW'(CHANNELS - 1));
  assign len_m1  = (len_q == '0) ? '0 : len_q - 1'b1;

  always_comb begin
    src_x   = {{(GAIN_W + 1){fb_src[DATA_W-1]}}, fb_src};
    gain_x  = {{(DATA_W + 1){1'b0}}, fb_q};
    prod    = src_x * gain_x;
    prod_sh = prod >>> GAIN_W;
    in_x    = {{(GAIN_W + 1){in_ch[DATA_W-1]}}, in_ch};
    sum     = in_x + prod_sh;
    if (sum > SMAX) begin
      wr_data = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (sum < SMIN) begin
      wr_data = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      wr_data = sum[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wr_data;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        if (clr_q == MAW'(NWORDS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = enable ? S_RD : S_DONE;
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        mem_we  = 1'b1;
        state_d = last_ch ? S_DONE : S_RD;
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == S_RD) rd_q <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
      ch_q    <= '0;
      wp_q    <= '0;
      len_q   <= '0;
      fb_q    <= '0;
      en_q    <= 1'b0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_CLEAR: clr_q <= clr_q + 1'b1;
        S_IDLE: begin
          if (in_valid) begin
            in_q  <= in_data;
            len_q <= delay_len;
            fb_q  <= feedback;
            en_q  <= enable;
            ch_q  <= '0;
            if (!enable) out_q <= in_data;
          end
        end
        S_WR: begin
          out_q[ch_q*DATA_W +: DATA_W] <= rd_q;
          if (!last_ch) ch_q <= ch_q + 1'b1;
        end
        S_DONE: begin
          if (en_q) wp_q <= (wp_q >= len_m1) ? '0 : wp_q + 1'b1;
          else      wp_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef COMB_DAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) lp_q[i] <= '0;
    end else if (state_q == S_WR) begin
      lp_q[ch_q] <= lp_new;
    end
  end
`endif

  assign out_data = out_q;

endmodule

// File: tb/tb_comb_filter_mc.sv
// Randomised and directed bench for comb_filter_mc against a frame-level reference model.
module tb_comb_filter_mc;
  localparam int DW = 32, DEPTH = 2048, CH = 2, GW = 8, DS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [10:0]   delay_len = '0;
  logic [7:0]    feedback = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          out_valid;
  logic [63:0]   out_data;

  comb_filter_mc #(.DATA_W(DW), .DEPTH(DEPTH), .CHANNELS(CH), .GAIN_W(GW), .DAMP_SHIFT(DS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delay_len(delay_len), .feedback(feedback),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel delay memory, write pointer, damping state
  int     m_mem [CH][DEPTH];
  int     m_wp;
  longint m_lp [CH];

  typedef struct { longint cyc; logic [63:0] data; } exp_t;
  exp_t q[$];
  logic [63:0] last_out;

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < DEPTH; a++) m_mem[c][a] = 0;
      m_lp[c] = 0;
    end
    m_wp = 0;
  endtask

  function automatic logic [63:0] model_frame(input bit en, input int len, input int g,
                                              input logic [31:0] d0, input logic [31:0] d1);
    logic [63:0] r;
    logic [31:0] din;
    longint dl, src, fbv, s;
    int L;
    if (!en) begin
      m_wp = 0;
      return {d1, d0};
    end
    L = (len == 0) ? 1 : len;
    for (int c = 0; c < CH; c++) begin
      din = (c == 0) ? d0 : d1;
      dl = longint'(m_mem[c][m_wp]);
      r[c*32 +: 32] = dl[31:0];
`ifdef COMB_DAMP_EN
      m_lp[c] = m_lp[c] + ((dl - m_lp[c]) >>> DS);
      src = m_lp[c];
`else
      src = dl;
`endif
      fbv = (src * longint'(g)) >>> GW;
      s = sat(longint'(int'(din)) + fbv);
      m_mem[c][m_wp] = int'(s);
    end
    m_wp = (m_wp >= L - 1) ? 0 : m_wp + 1;
    return r;
  endfunction

  // Compare process: every out_valid pulse must match the next expected frame and cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      chk("missing_out_valid", 64'(cyc), 64'(e.cyc));
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_latency", 64'(cyc), 64'(e.cyc));
        chk("out_data", out_data, e.data);
        last_out = out_data;
      end
    end
  end

  task automatic send(input bit en, input int len, input int g,
                      input logic [31:0] d0, input logic [31:0] d1, input int gap);
    int t = 0;
    exp_t e;
    repeat (gap) @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    enable    = en;
    delay_len = 11'(len);
    feedback  = 8'(g);
    in_data   = {d1, d0};
    in_valid  = 1'b1;
    e.cyc  = cyc + (en ? 2 * CH + 1 : 1);
    e.data = model_frame(en, len, g, d0, d1);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 64'(64'h0BAD_0BAD_0BAD_0BAD);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic frame(input bit en, input int len, input int g,
                       input logic [31:0] d0, input logic [31:0] d1);
    send(en, len, g, d0, d1, 0);
    drain();
  endtask

  task automatic reset_and_clear();
    int n = 0;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    while (!in_ready && n < 10000) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", 64'(n), 64'(CH * DEPTH));
  endtask

  initial begin
    logic [31:0] r0, r1;
    model_reset();
    @(negedge clk);
    reset_and_clear();

    // Bypass, then re-enable: nothing replayed, memory still cleared
    frame(1'b0, 2, 0, 32'd5, -32'sd7);
    chk("bypass_data", last_out, {32'hFFFF_FFF9, 32'd5});
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 2, 0, 32'd0, 32'd0);
      if (i >= 2) chk("reenable_no_replay", last_out, 64'd0);
    end

    // Pure delay line, L=4
    for (int i = 0; i < 7; i++) begin
      if (i == 0) frame(1'b1, 4, 0, 32'd1000, -32'sd1000);
      else        frame(1'b1, 4, 0, 32'd0, 32'd0);
      if (i == 0) chk("delay4_f0", last_out, 64'd0);
      if (i == 4) chk("delay4_f4", last_out, {32'hFFFF_FC18, 32'd1000});
      if (i == 5) chk("delay4_f5", last_out, 64'd0);
    end

    // Feedback 0.5, L=3; a zero frame first brings wp back inside the new length
    frame(1'b1, 3, 128, 32'd0, 32'd0);
    for (int i = 0; i <= 12; i++) begin
      frame(1'b1, 3, 128, (i == 0) ? 32'd1024 : 32'd0, 32'd0);
`ifndef COMB_DAMP_EN
      if (i == 3)  chk("fb_half_f3",  last_out, 64'd1024);
      if (i == 6)  chk("fb_half_f6",  last_out, 64'd512);
      if (i == 9)  chk("fb_half_f9",  last_out, 64'd256);
      if (i == 12) chk("fb_half_f12", last_out, 64'd128);
`endif
    end

    // Saturation at both rails
    for (int i = 0; i < 4; i++) frame(1'b1, 1, 255, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("sat_rails", last_out, {32'h8000_0000, 32'h7FFF_FFFF});

    // Randomised traffic, including delay_len=0 and shrinking lengths
    for (int i = 0; i < 60; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      if ($urandom_range(0, 7) == 0) r0 = 32'h7FFF_FFFF;
      if ($urandom_range(0, 7) == 0) r1 = 32'h8000_0000;
      send($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
           r0, r1, $urandom_range(0, 3));
    end
    drain();

    // Reset during WR of ch1
    send(1'b1, 2, 100, 32'd77, 32'd88, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_out_valid", 64'(out_valid), 64'd0);
    chk("midframe_in_ready", 64'(in_ready), 64'd0);
    reset_and_clear();

    // Impulse with max gain, L=1: second round fb shows whether damping is applied
    frame(1'b1, 1, 255, 32'd400, 32'd0);
    frame(1'b1, 1, 255, 32'd0, 32'd0);
    chk("impulse_round1", last_out, 64'd400);
    frame(1'b1, 1, 255, 32'd0, 32'd0);
`ifdef COMB_DAMP_EN
    chk("impulse_round2_damped", last_out, 64'd99);
`else
    chk("impulse_round2", last_out, 64'd398);
`endif

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
